// File: rtl/apb_matmul_slave_if.sv
// apb_matmul_slave_if: APB slave front-end for the matrix engine.
// Decodes and validates APB transfers, inserts wait states, emits single-cycle
// backend register strobes and owns the sticky STATUS register and done irq.
module apb_matmul_slave_if #(
  parameter  int DATA_WIDTH  = 16,
  parameter  int BUS_WIDTH   = 64,
  parameter  int ADDR_WIDTH  = 32,
  parameter  int SP_NTARGETS = 4,
  parameter  int WAIT_STATES = 0,
  localparam int MAX_DIM     = BUS_WIDTH / DATA_WIDTH,
  localparam int OFS         = $clog2(BUS_WIDTH / 8),
  localparam int RW          = $clog2(MAX_DIM),
  localparam int NOVF        = MAX_DIM * MAX_DIM
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [MAX_DIM-1:0]    pstrb_i,
  input  logic [ADDR_WIDTH-1:0] paddr_i,
  input  logic [BUS_WIDTH-1:0]  pwdata_i,
  output logic                  pready_o,
  output logic                  pslverr_o,
  output logic [BUS_WIDTH-1:0]  prdata_o,
  output logic                  reg_wr_o,
  output logic                  reg_rd_o,
  output logic [4:0]            reg_mod_o,
  output logic [RW-1:0]         reg_row_o,
  output logic [MAX_DIM-1:0]    reg_strb_o,
  output logic [BUS_WIDTH-1:0]  reg_wdata_o,
  input  logic [BUS_WIDTH-1:0]  reg_rdata_i,
  input  logic                  busy_i,
  input  logic                  done_i,
  input  logic [NOVF-1:0]       ovf_i,
  output logic                  busy_o,
  output logic                  irq_o
);

  localparam int MODW = 5;
  localparam int ALO  = OFS + RW + MODW;  // lowest address bit not decoded

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_e;

  state_e               state_q, state_d;
  logic [OFS-1:0]       off_q, off_d;
  logic [RW-1:0]        row_q, row_d;
  logic [MODW-1:0]      mod_q, mod_d;
  logic                 wr_q, wr_d;
  logic [BUS_WIDTH-1:0] wdata_q, wdata_d;
  logic [MAX_DIM-1:0]   strb_q, strb_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 eval_q, eval_d;
  logic                 err_q, err_d;
  logic                 rd_pend_q, rd_pend_d;
  logic                 data_ok_q, data_ok_d;
  logic [BUS_WIDTH-1:0] rdata_q, rdata_d;
  logic                 reg_wr_q, reg_wr_d;
  logic                 reg_rd_q, reg_rd_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [NOVF-1:0]      ovf_q, ovf_d;
  logic                 irq_en_q, irq_en_d;
  logic                 irq_q, irq_d;

  logic                 setup, eval_now, is_status, is_sp, mod_oob, reject;
  logic                 need_rd, ready, status_wr, clr_done;
  logic [NOVF-1:0]      clr_ovf;
  logic [BUS_WIDTH-1:0] status_rd;
  logic                 unused_addr;

  // Upper address bits above the module field are not decoded.
  assign unused_addr = ^paddr_i[ADDR_WIDTH-1:ALO];

  // Access classification of the latched request and STATUS read/clear terms.
  // NOTE: every signal gets a default at the top of an always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    setup     = psel_i & ~penable_i;
    eval_now  = (state_q == ST_ACCESS) & psel_i & penable_i & ~eval_q;
    is_status = (mod_q == MODW'(3));
    is_sp     = (mod_q >= MODW'(4));
    mod_oob   = (int'(mod_q) > 3 + SP_NTARGETS);
    reject    = (off_q != '0) | mod_oob | (is_sp & wr_q)
              | (busy_i & wr_q & (mod_q <= MODW'(2)))
              | (busy_i & ~wr_q & is_sp);
    need_rd   = ~wr_q & ~is_status & ~reject;
    // Response may leave ACCESS once the evaluated access has its data.
    ready     = eval_now ? ~need_rd : (data_ok_q | rd_pend_q);
    status_wr = eval_now & ~reject & is_status & wr_q;
    clr_done  = status_wr & wdata_q[1] & strb_q[1 / DATA_WIDTH];
    for (int i = 0; i < NOVF; i++) begin
      clr_ovf[i] = status_wr & wdata_q[2 + i] & strb_q[(2 + i) / DATA_WIDTH];
    end
    status_rd                = '0;
    status_rd[0]             = busy_i;
    status_rd[1]             = done_q;
    status_rd[2 +: NOVF]     = ovf_q;
    status_rd[BUS_WIDTH - 1] = irq_en_q;
  end

  // Next-state logic of the transfer FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (setup) state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (!psel_i) begin
          state_d = ST_IDLE;
        end else if ((cnt_q == '0) && (eval_q || eval_now) && ready) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Request latch, wait counter, backend strobes, read capture and STATUS update.
  always_comb begin
    off_d     = off_q;
    row_d     = row_q;
    mod_d     = mod_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    cnt_d     = cnt_q;
    eval_d    = eval_q;
    err_d     = err_q;
    data_ok_d = data_ok_q;
    rdata_d   = rdata_q;
    reg_wr_d  = 1'b0;
    reg_rd_d  = 1'b0;
    rd_pend_d = reg_rd_q;
    if ((state_q == ST_IDLE) && setup) begin
      off_d     = paddr_i[OFS-1:0];
      row_d     = paddr_i[OFS +: RW];
      mod_d     = paddr_i[OFS + RW +: MODW];
      wr_d      = pwrite_i;
      wdata_d   = pwdata_i;
      strb_d    = pstrb_i;
      cnt_d     = 4'(WAIT_STATES);
      eval_d    = 1'b0;
      err_d     = 1'b0;
      data_ok_d = 1'b0;
      rdata_d   = '0;
    end
    if (state_q == ST_ACCESS) begin
      if (cnt_q != '0) cnt_d = cnt_q - 4'd1;
      if (eval_now) begin
        eval_d    = 1'b1;
        err_d     = reject;
        data_ok_d = ~need_rd;
        rdata_d   = (~reject & is_status & ~wr_q) ? status_rd : '0;
        reg_wr_d  = ~reject & wr_q & ~is_status;
        reg_rd_d  = need_rd;
      end
      // Backend data is valid the cycle after the read strobe.
      if (rd_pend_q) begin
        rdata_d   = reg_rdata_i;
        data_ok_d = 1'b1;
      end
    end
    done_d   = done_i | (done_q & ~clr_done);
    ovf_d    = ovf_i | (ovf_q & ~clr_ovf);
    irq_en_d = (status_wr & strb_q[MAX_DIM-1]) ? wdata_q[BUS_WIDTH-1] : irq_en_q;
    irq_d    = done_q & irq_en_q;
    busy_d   = busy_i;
  end

  // APB response outputs, driven only during the single RESP cycle.
  always_comb begin
    pready_o  = (state_q == ST_RESP);
    pslverr_o = pready_o & err_q;
    prdata_o  = pready_o ? rdata_q : '0;
  end

  assign reg_wr_o    = reg_wr_q;
  assign reg_rd_o    = reg_rd_q;
  assign reg_mod_o   = mod_q;
  assign reg_row_o   = row_q;
  assign reg_strb_o  = strb_q;
  assign reg_wdata_o = wdata_q;
  assign busy_o      = busy_q;
  assign irq_o       = irq_q;

  // State register with synchronous active-high reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_ni) begin
      state_q   <= ST_IDLE;
      off_q     <= '0;
      row_q     <= '0;
      mod_q     <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      cnt_q     <= '0;
      eval_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_pend_q <= 1'b0;
      data_ok_q <= 1'b0;
      rdata_q   <= '0;
      reg_wr_q  <= 1'b0;
      reg_rd_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= '0;
      irq_en_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      off_q     <= off_d;
      row_q     <= row_d;
      mod_q     <= mod_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      cnt_q     <= cnt_d;
      eval_q    <= eval_d;
      err_q     <= err_d;
      rd_pend_q <= rd_pend_d;
      data_ok_q <= data_ok_d;
      rdata_q   <= rdata_d;
      reg_wr_q  <= reg_wr_d;
      reg_rd_q  <= reg_rd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      irq_en_q  <= irq_en_d;
      irq_q     <= irq_d;
    end
  end

endmodule

// File: tb/tb_apb_matmul_slave_if.sv
// Bench for apb_matmul_slave_if: two instances (WAIT_STATES 0 and 3) share the
// APB bus apart from psel; a table of transfers plus STATUS, abort and reset sequences.
module tb_apb_matmul_slave_if;

  localparam int BW = 64;
  localparam int MD = 4;
  localparam int AW = 32;

  typedef struct {
    int          dut;
    bit          wr;
    logic [AW-1:0] addr;
    logic [4:0]  mod;
    logic [1:0]  row;
    logic [BW-1:0] wdata;
    logic [MD-1:0] strb;
    bit          busy;
    logic [BW-1:0] bk;
    bit          err;
    logic [BW-1:0] rdata;
    int          lat;
    int          nwr;
    int          nrd;
    bit          pulse_done;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_ni = 1'b1;
  logic [1:0]    psel = '0;
  logic          penable = 1'b0, pwrite = 1'b0;
  logic [MD-1:0] pstrb = '0;
  logic [AW-1:0] paddr = '0;
  logic [BW-1:0] pwdata = '0, bk_data = '0, reg_rdata;
  logic          busy_i = 1'b0, done_i = 1'b0;
  logic [15:0]   ovf_i = '0;
  logic          rd_d1 = 1'b0;

  logic          pready [2], pslverr [2], reg_wr [2], reg_rd [2], busy_o [2], irq [2];
  logic [BW-1:0] prdata [2], reg_wdata [2];
  logic [4:0]    reg_mod [2];
  logic [1:0]    reg_row [2];
  logic [MD-1:0] reg_strb [2];

  apb_matmul_slave_if #(.WAIT_STATES(0)) u_dut0 (
    .clk_i(clk), .reset_ni(reset_ni), .psel_i(psel[0]), .penable_i(penable),
    .pwrite_i(pwrite), .pstrb_i(pstrb), .paddr_i(paddr), .pwdata_i(pwdata),
    .pready_o(pready[0]), .pslverr_o(pslverr[0]), .prdata_o(prdata[0]),
    .reg_wr_o(reg_wr[0]), .reg_rd_o(reg_rd[0]), .reg_mod_o(reg_mod[0]),
    .reg_row_o(reg_row[0]), .reg_strb_o(reg_strb[0]), .reg_wdata_o(reg_wdata[0]),
    .reg_rdata_i(reg_rdata), .busy_i(busy_i), .done_i(done_i), .ovf_i(ovf_i),
    .busy_o(busy_o[0]), .irq_o(irq[0])
  );

  apb_matmul_slave_if #(.WAIT_STATES(3)) u_dut3 (
    .clk_i(clk), .reset_ni(reset_ni), .psel_i(psel[1]), .penable_i(penable),
    .pwrite_i(pwrite), .pstrb_i(pstrb), .paddr_i(paddr), .pwdata_i(pwdata),
    .pready_o(pready[1]), .pslverr_o(pslverr[1]), .prdata_o(prdata[1]),
    .reg_wr_o(reg_wr[1]), .reg_rd_o(reg_rd[1]), .reg_mod_o(reg_mod[1]),
    .reg_row_o(reg_row[1]), .reg_strb_o(reg_strb[1]), .reg_wdata_o(reg_wdata[1]),
    .reg_rdata_i(reg_rdata), .busy_i(busy_i), .done_i(done_i), .ovf_i(ovf_i),
    .busy_o(busy_o[1]), .irq_o(irq[1])
  );

  // Backend model: read data is valid only in the cycle after a read strobe.
  always @(posedge clk) rd_d1 <= reg_rd[0] | reg_rd[1];
  assign reg_rdata = rd_d1 ? bk_data : 64'hBAD0_BAD0_BAD0_BAD0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe / ready monitor: free-running counters and last strobe attributes.
  int            wr_cnt [2] = '{0, 0};
  int            rd_cnt [2] = '{0, 0};
  int            rdy_cnt [2] = '{0, 0};
  logic [4:0]    last_mod [2];
  logic [1:0]    last_row [2];
  logic [BW-1:0] last_wdata [2];
  logic [MD-1:0] last_strb [2];
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reg_wr[d]) wr_cnt[d]++;
      if (reg_rd[d]) rd_cnt[d]++;
      if (pready[d]) rdy_cnt[d]++;
      if (reg_wr[d] || reg_rd[d]) begin
        last_mod[d]   = reg_mod[d];
        last_row[d]   = reg_row[d];
        last_wdata[d] = reg_wdata[d];
        last_strb[d]  = reg_strb[d];
      end
    end
  end

  int   n_checks = 0;
  int   n_fail   = 0;
  int   setup_cyc;
  vec_t sb_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int dut, input bit wr, input int mod, input int row,
                              input int off, input logic [BW-1:0] wdata, input logic [MD-1:0] strb,
                              input bit busy, input logic [BW-1:0] bk, input bit err,
                              input logic [BW-1:0] rdata, input int lat, input int nwr, input int nrd);
    vec_t v;
    v.dut = dut; v.wr = wr; v.mod = 5'(mod); v.row = 2'(row);
    v.addr = AW'((mod << 5) | (row << 3) | off);
    v.wdata = wdata; v.strb = strb; v.busy = busy; v.bk = bk; v.err = err;
    v.rdata = rdata; v.lat = lat; v.nwr = nwr; v.nrd = nrd; v.pulse_done = 1'b0;
    return v;
  endfunction

  // One complete APB transfer; expectation pushed at SETUP, popped at pready.
  task automatic xfer(input vec_t v);
    int   d;
    int   w0, r0;
    bit   got;
    vec_t e;
    d  = v.dut;
    w0 = wr_cnt[d];
    r0 = rd_cnt[d];
    @(posedge clk); #1;
    busy_i = v.busy; bk_data = v.bk;
    psel[d] = 1'b1; penable = 1'b0; pwrite = v.wr; paddr = v.addr;
    pwdata = v.wdata; pstrb = v.strb;
    setup_cyc = cyc;
    sb_q.push_back(v);
    @(posedge clk); #1;
    penable = 1'b1;
    done_i  = v.pulse_done;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (pready[d]) begin
        got = 1'b1;
        e = sb_q.pop_front();
        check("pslverr", 64'(pslverr[d]), 64'(e.err));
        check("prdata", prdata[d], e.rdata);
        check("latency", 64'(cyc - setup_cyc), 64'(e.lat));
      end
      @(posedge clk); #1;
      done_i = 1'b0;
    end
    if (!got) begin
      check("pready_timeout", 64'(got), 64'd1);
      if (sb_q.size() != 0) void'(sb_q.pop_front());
    end
    psel[d] = 1'b0; penable = 1'b0;
    @(negedge clk);
    check("pready_one_cycle", 64'(pready[d]), 64'd0);
    check("wr_strobes", 64'(wr_cnt[d] - w0), 64'(v.nwr));
    check("rd_strobes", 64'(rd_cnt[d] - r0), 64'(v.nrd));
    if (v.nwr + v.nrd > 0) begin
      check("reg_mod", 64'(last_mod[d]), 64'(v.mod));
      check("reg_row", 64'(last_row[d]), 64'(v.row));
    end
    if (v.nwr > 0) begin
      check("reg_wdata", last_wdata[d], v.wdata);
      check("reg_strb", 64'(last_strb[d]), 64'(v.strb));
    end
  endtask

  task automatic status_rw(input bit wr, input logic [BW-1:0] wdata, input logic [MD-1:0] strb,
                           input logic [BW-1:0] rdata, input bit pulse_done);
    vec_t v;
    v = mk(0, wr, 3, 0, 0, wdata, strb, 1'b0, '0, 1'b0, rdata, 2, 0, 0);
    v.pulse_done = pulse_done;
    xfer(v);
  endtask

  vec_t vecs [15];

  initial begin
    int r0, w0, q0, q1;
    vec_t v;

    vecs[0]  = mk(0, 1, 0, 0, 0, 64'h11, 4'hF, 0, '0, 0, '0, 2, 1, 0);          // CTRL write
    vecs[1]  = mk(0, 1, 2, 2, 0, 64'h1234, 4'hF, 1, '0, 1, '0, 2, 0, 0);        // busy write 0..2
    vecs[2]  = mk(0, 0, 3, 0, 0, '0, 4'hF, 1, '0, 0, 64'h1, 2, 0, 0);           // STATUS busy bit
    vecs[3]  = mk(1, 0, 5, 3, 0, '0, 4'hF, 0, 64'hDEAD_BEEF_0123_4567, 0,
                  64'hDEAD_BEEF_0123_4567, 5, 0, 1);                             // SP read, 3 waits
    vecs[4]  = mk(0, 0, 5, 3, 0, '0, 4'hF, 0, 64'h0F0F_1234_5678_9ABC, 0,
                  64'h0F0F_1234_5678_9ABC, 4, 0, 1);                             // SP read, no waits
    vecs[5]  = mk(0, 1, 0, 0, 4, 64'h77, 4'hF, 0, '0, 1, '0, 2, 0, 0);          // misaligned
    vecs[6]  = mk(0, 0, 9, 0, 0, '0, 4'hF, 0, 64'h5555, 1, '0, 2, 0, 0);        // module 9
    vecs[7]  = mk(0, 1, 4, 1, 0, 64'hAA, 4'hF, 0, '0, 1, '0, 2, 0, 0);          // SP write
    vecs[8]  = mk(0, 0, 4, 0, 0, '0, 4'hF, 1, 64'h77, 1, '0, 2, 0, 0);          // busy SP read
    vecs[9]  = mk(0, 0, 1, 1, 0, '0, 4'hF, 1, 64'h1111_2222_3333_4444, 0,
                  64'h1111_2222_3333_4444, 4, 0, 1);                             // busy OPA read ok
    vecs[10] = mk(1, 1, 2, 0, 0, 64'hCAFE, 4'b0101, 0, '0, 0, '0, 5, 1, 0);     // OPB write, 3 waits
    vecs[11] = mk(1, 0, 3, 0, 1, '0, 4'hF, 0, '0, 1, '0, 5, 0, 0);              // misaligned, 3 waits
    vecs[12] = mk(0, 0, 7, 2, 0, '0, 4'hF, 0, 64'h9999, 0, 64'h9999, 4, 0, 1);  // last SP target
    vecs[13] = mk(0, 0, 8, 0, 0, '0, 4'hF, 0, 64'h8888, 1, '0, 2, 0, 0);        // first bad module
    vecs[14] = mk(1, 0, 3, 0, 0, '0, 4'hF, 1, '0, 0, 64'h1, 5, 0, 0);           // STATUS, 3 waits

    repeat (3) @(posedge clk);
    #1 reset_ni = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_pready", 64'(pready[d]), 64'd0);
      check("rst_pslverr", 64'(pslverr[d]), 64'd0);
      check("rst_prdata", prdata[d], 64'd0);
      check("rst_strobes", 64'(reg_wr[d] | reg_rd[d]), 64'd0);
      check("rst_reg_mod", 64'(reg_mod[d]), 64'd0);
      check("rst_reg_wdata", reg_wdata[d], 64'd0);
      check("rst_irq", 64'(irq[d]), 64'd0);
      check("rst_busy_o", 64'(busy_o[d]), 64'd0);
    end

    @(posedge clk); #1 busy_i = 1'b1;
    @(posedge clk); @(negedge clk);
    check("busy_o_copy", 64'(busy_o[0]), 64'd1);
    #1 busy_i = 1'b0;

    for (int i = 0; i < 15; i++) xfer(vecs[i]);

    // STATUS: irq_en, sticky set, lane-respecting clear, set-beats-clear.
    status_rw(1'b1, 64'h8000_0000_0000_0000, 4'b1000, '0, 1'b0);
    @(posedge clk); #1 ovf_i = 16'h0020; done_i = 1'b1;
    @(posedge clk); #1 ovf_i = '0; done_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("irq_set", 64'(irq[0]), 64'd1);
    status_rw(1'b0, '0, 4'hF, 64'h8000_0000_0000_0082, 1'b0);
    status_rw(1'b1, 64'h80, 4'b0010, '0, 1'b0);
    status_rw(1'b0, '0, 4'hF, 64'h8000_0000_0000_0082, 1'b0);
    status_rw(1'b1, 64'h82, 4'b0001, '0, 1'b1);
    status_rw(1'b0, '0, 4'hF, 64'h8000_0000_0000_0002, 1'b0);
    check("irq_held", 64'(irq[0]), 64'd1);
    status_rw(1'b1, 64'h2, 4'b0001, '0, 1'b0);
    status_rw(1'b0, '0, 4'hF, 64'h8000_0000_0000_0000, 1'b0);
    check("irq_cleared", 64'(irq[0]), 64'd0);

    // penable high while idle is ignored.
    q0 = rdy_cnt[0]; w0 = wr_cnt[0]; r0 = rd_cnt[0];
    @(posedge clk); #1 psel[0] = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = '0;
    repeat (3) @(posedge clk);
    #1 psel[0] = 1'b0; penable = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_penable_ready", 64'(rdy_cnt[0] - q0), 64'd0);
    check("idle_penable_strobes", 64'((wr_cnt[0] - w0) + (rd_cnt[0] - r0)), 64'd0);

    // psel drop mid-ACCESS: write already issued stands, no pready.
    q1 = rdy_cnt[1]; w0 = wr_cnt[1];
    @(posedge clk); #1 psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h28;
    pwdata = 64'h5A5A; pstrb = 4'hF;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 psel[1] = 1'b0; penable = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_no_ready", 64'(rdy_cnt[1] - q1), 64'd0);
    check("abort_write_stands", 64'(wr_cnt[1] - w0), 64'd1);
    xfer(vecs[10]);

    // Reset in the middle of a backend read.
    q0 = rdy_cnt[0];
    @(posedge clk); #1 psel[0] = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h28;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 reset_ni = 1'b1;
    @(posedge clk); #1 reset_ni = 1'b0; psel[0] = 1'b0; penable = 1'b0;
    repeat (6) @(negedge clk);
    check("reset_no_ready", 64'(rdy_cnt[0] - q0), 64'd0);
    check("reset_reg_mod", 64'(reg_mod[0]), 64'd0);
    v = vecs[0];
    xfer(v);
    status_rw(1'b0, '0, 4'hF, 64'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
